// File: rtl/mem_responder_pkg.sv
// Shared bus encodings, tag-table sizing and the slot record for the memory responder.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_responder_pkg;

    // proc2mem command encodings; 2'b11 is deliberately left unnamed and behaves as no-op
    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_command_t;

    // Tag 0 means "no tag", so 4 bits give 15 usable transaction tags
    localparam int NUM_MEM_TAGS = 15;
    localparam int TAG_W        = 4;

    // One in-flight transaction: countdown runs from LATENCY to zero
    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [3:0]  count;
        logic [63:0] data;
    } mem_slot_t;

    // True only for commands that occupy a slot
    function automatic logic is_mem_op(input logic [1:0] cmd);
        return (cmd == BUS_LOAD) || (cmd == BUS_STORE);
    endfunction

endpackage

// File: rtl/mem_tag_alloc.sv
// Lowest-index free-slot finder: maps a free vector to tag (index+1) and an any-free flag.
// Latency: purely combinational.
// Backpressure: any_free_o low tells the caller no tag can be handed out this cycle.
module mem_tag_alloc
    import mem_responder_pkg::*;
(
    input  logic [NUM_MEM_TAGS-1:0] free_i,
    output logic [TAG_W-1:0]        tag_o,
    output logic                    any_free_o
);

    // Scan high to low so the lowest free index is the last (winning) assignment
    always_comb begin
        tag_o = '0;
        for (int i = NUM_MEM_TAGS - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                tag_o = TAG_W'(i + 1);
            end
        end
    end

    assign any_free_o = |free_i;

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory model: tags each accepted load/store and returns load data after LATENCY.
// Latency: response is same-cycle combinational; load data appears right after accept edge + LATENCY.
// Backpressure: response 0 means retry; given when no slot is free or MAX_OUTSTANDING is reached.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY         = 10,
    parameter int MAX_OUTSTANDING = 15,
    parameter int MEM_WORDS       = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag
);

    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_C = 4'(LATENCY);
    localparam logic [4:0] MAX_C = 5'(MAX_OUTSTANDING);

    mem_slot_t [NUM_MEM_TAGS-1:0] slots_q;
    mem_slot_t [NUM_MEM_TAGS-1:0] slots_d;
    logic [63:0]                  mem_q [MEM_WORDS];

    logic [3:0]               ret_tag_q;
    logic [3:0]               ret_tag_d;
    logic [63:0]              ret_data_q;
    logic [63:0]              ret_data_d;

    logic [NUM_MEM_TAGS-1:0]  free_vec;
    logic [4:0]               occupied;
    logic [TAG_W-1:0]         alloc_tag;
    logic [TAG_W-1:0]         alloc_idx;
    logic                     any_free;
    logic                     is_load;
    logic                     accept;
    logic [IDX_W-1:0]         word_idx;
    logic [3:0]               num_done;
    logic                     addr_unused;

    // Free vector and occupancy come straight from the registered slot table
    always_comb begin
        free_vec = '0;
        occupied = '0;
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            free_vec[i] = !slots_q[i].valid;
            occupied    = occupied + 5'(slots_q[i].valid);
        end
    end

    mem_tag_alloc u_tag_alloc (
        .free_i     (free_vec),
        .tag_o      (alloc_tag),
        .any_free_o (any_free)
    );

    // A slot freed at this edge only becomes visible to the allocator next cycle,
    // because free_vec is built from slots_q rather than slots_d.
    assign is_load   = (proc2mem_command == BUS_LOAD);
    assign accept    = !reset && is_mem_op(proc2mem_command) && any_free && (occupied < MAX_C);
    assign alloc_idx = alloc_tag - 4'd1;

    assign mem2proc_response = accept ? alloc_tag : '0;

    // Word index ignores the byte offset and everything above the array size (addresses wrap)
    assign word_idx    = proc2mem_addr[3 +: IDX_W];
    assign addr_unused = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

    // Countdown, completion and allocation for every slot
    always_comb begin
        slots_d    = slots_q;
        ret_tag_d  = '0;
        ret_data_d = '0;
        num_done   = '0;
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            if (slots_q[i].valid) begin
                if (slots_q[i].count == 4'd1) begin
                    // Countdown hits zero on this edge: retire the slot
                    slots_d[i] = '0;
                    num_done   = num_done + 4'd1;
                    if (slots_q[i].is_load) begin
                        ret_tag_d  = 4'(i + 1);
                        ret_data_d = slots_q[i].data;
                    end
                end else begin
                    slots_d[i].count = slots_q[i].count - 4'd1;
                end
            end
        end
        if (accept) begin
            slots_d[alloc_idx].valid   = 1'b1;
            slots_d[alloc_idx].is_load = is_load;
            slots_d[alloc_idx].count   = LAT_C;
            slots_d[alloc_idx].data    = is_load ? mem_q[word_idx] : 64'd0;
        end
    end

    // Slot table and return registers; reset drops every in-flight transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            slots_q    <= '0;
            ret_tag_q  <= '0;
            ret_data_q <= '0;
        end else begin
            slots_q    <= slots_d;
            ret_tag_q  <= ret_tag_d;
            ret_data_q <= ret_data_d;
            // Fixed latency with one accept per cycle can never retire two slots at once
            assert (num_done <= 4'd1);
        end
    end

    // Backing array: stores land at the accepting edge and survive reset
    always_ff @(posedge clock) begin
        if (accept && !is_load) begin
            mem_q[word_idx] <= proc2mem_data;
        end
    end

    assign mem2proc_tag  = ret_tag_q;
    assign mem2proc_data = ret_data_q;

endmodule
